// File: rtl/sram_pkg.sv
// sram_pkg: shared types and constants for the external 16-bit SRAM controller
package sram_pkg;
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;
    localparam logic [31:0] MEM_BASE_DEF = 32'd1024;
    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: splits each 32-bit load/store into two timed half-word SRAM accesses, low half first
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int          WAIT_CYC = 2,
    parameter logic [31:0] MEM_BASE = MEM_BASE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_o,
    input  logic [SRAM_DW-1:0] sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);
    localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYC - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               rd_q, rd_d;
    logic [SRAM_AW-2:0] word_q, word_d;
    logic [31:0]        wdata_q, wdata_d, rdata_q, rdata_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic               req, busy, last;

    always_comb begin
        req     = rd_en | wr_en;
        busy    = (state_q == LOW) || (state_q == HIGH);
        last    = cnt_q == LAST;
        state_d = state_q;
        cnt_d   = busy ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
        rd_d    = rd_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: if (req) begin
                state_d = LOW;
                cnt_d   = '0;
                rd_d    = rd_en;
                word_d  = (SRAM_AW-1)'((address - MEM_BASE) >> 2);
                wdata_d = wdata;
            end
            LOW: if (last) begin
                state_d = HIGH;
                if (rd_q) rdata_d[15:0] = sram_dq_i;
            end
            HIGH: if (last) begin
                state_d = DONE;
                if (rd_q) rdata_d[31:16] = sram_dq_i;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // the address register only tracks the active phase so it holds its last value when idle
        addr_d     = busy ? {word_q, state_q == HIGH} : addr_q;
        sram_addr  = addr_d;
        sram_dq_oe = busy & ~rd_q;
        sram_we_n  = ~(sram_dq_oe & ~last);
        sram_dq_o  = (state_q == HIGH) ? wdata_q[31:16] : (state_q == LOW) ? wdata_q[15:0] : '0;
        ready      = ~req | (state_q == DONE);
        rdata      = rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
        end
    end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: randomized self-checking bench for sram_ctrl with a behavioural SRAM and reference memory
module tb_sram_ctrl;
    localparam int W = 2;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0, rst = 1'b1;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [31:0] address = '0, wdata = '0, rdata;
    logic        ready, sram_dq_oe, sram_we_n;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o, sram_dq_i;

    logic        rd3 = 1'b0;
    logic [31:0] addr3 = '0, rdata3;
    logic        ready3, oe3, wen3;
    logic [17:0] sa3;
    logic [15:0] dqo3, dqi3;
    logic [15:0] mem3 [0:1];

    logic [15:0] mem [0:(1<<18)-1];
    logic        pre_we = 1'b0;
    logic [17:0] pre_a = '0;
    logic [15:0] pre_d = '0;
    logic [15:0] ref_mem [int];
    logic [31:0] exp_rdata = '0;
    int          n_chk = 0, n_pass = 0, we_fall = 0, we_low = 0;

    always #5 clk = ~clk;

    sram_ctrl dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address), .wdata(wdata),
        .rdata(rdata), .ready(ready), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
        .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    sram_ctrl #(.WAIT_CYC(3)) dut3 (
        .clk(clk), .rst(rst), .rd_en(rd3), .wr_en(1'b0), .address(addr3), .wdata(32'h0),
        .rdata(rdata3), .ready(ready3), .sram_addr(sa3), .sram_dq_o(dqo3),
        .sram_dq_i(dqi3), .sram_dq_oe(oe3), .sram_we_n(wen3)
    );

    // SRAM latches on the rising edge of we_n; an edge caused by reset aborts the write
    always @(posedge sram_we_n or posedge pre_we)
        if (pre_we) mem[pre_a] <= pre_d;
        else if (rst === 1'b0) mem[sram_addr] <= sram_dq_o;
    assign sram_dq_i = mem[sram_addr];
    assign dqi3 = mem3[sa3[0]];

    always @(negedge sram_we_n) we_fall++;
    always @(negedge clk) if (sram_we_n === 1'b0) we_low++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic preload(input int a, input logic [15:0] d);
        pre_a = 18'(a); pre_d = d; ref_mem[a] = d;
        #1 pre_we = 1'b1;
        #1 pre_we = 1'b0;
    endtask

    function automatic int hw(input logic [31:0] a, input bit hi);
        logic [16:0] wa;
        wa = 17'((a - BASE) >> 2);
        return 2 * int'(wa) + int'(hi);
    endfunction

    // starts right after a rising edge; returns one cycle past DONE with the request dropped
    task automatic do_op(input string tag, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        int k;
        rd_en = r; wr_en = w; address = a; wdata = d;
        we_fall = 0; we_low = 0; k = 0;
        #1 chk({tag, "_c0_ready"}, 32'(ready), 0);
        while (!ready && k < 50) begin
            @(posedge clk); #1; k++;
            if (!ready) begin
                chk({tag, "_addr"}, 32'(sram_addr), 32'(hw(a, k > W)));
                chk({tag, "_oe"}, 32'(sram_dq_oe), 32'(w & ~r));
            end
        end
        chk({tag, "_stall"}, k, 2 * W + 1);
        if (r) exp_rdata = {ref_mem[hw(a, 1)], ref_mem[hw(a, 0)]};
        else if (w) begin
            ref_mem[hw(a, 0)] = d[15:0];
            ref_mem[hw(a, 1)] = d[31:16];
        end
        chk({tag, "_rdata"}, rdata, exp_rdata);
        chk({tag, "_we_pulses"}, we_fall, (w & ~r) ? 2 : 0);
        chk({tag, "_we_low"}, we_low, (w & ~r) ? 2 * (W - 1) : 0);
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int k, bad;
        for (int i = 0; i < 128; i++) preload(i, 16'($urandom));
        preload(18'h3fffe, 16'($urandom));
        preload(18'h3ffff, 16'($urandom));
        preload(0, 16'h1234);
        preload(1, 16'hABCD);
        mem3[0] = 16'h5678; mem3[1] = 16'h9ABC;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", 32'(sram_addr), 0);
        chk("rst_dq_o", 32'(sram_dq_o), 0);
        chk("rst_oe", 32'(sram_dq_oe), 0);
        chk("rst_we_n", 32'(sram_we_n), 1);
        chk("rst_ready", 32'(ready), 1);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op("load", 1, 0, BASE, 32'h0);
        chk("load_word", rdata, 32'hABCD1234);
        do_op("store", 0, 1, 32'd1032, 32'hDEADBEEF);
        chk("store_lo", 32'(mem[4]), 32'hBEEF);
        chk("store_hi", 32'(mem[5]), 32'hDEAD);
        do_op("st_b2b", 0, 1, 32'd1036, 32'hCAFEF00D);
        do_op("ld_b2b", 1, 0, 32'd1036, 32'h0);
        chk("b2b_word", rdata, 32'hCAFEF00D);
        do_op("both", 1, 1, BASE, 32'h55AA55AA);
        chk("both_lo", 32'(mem[0]), 32'h1234);
        do_op("wrap", 1, 0, 32'd1023, 32'h0);

        repeat (10) begin
            @(posedge clk); #1;
            chk("idle_ready", 32'(ready), 1);
            chk("idle_we_n", 32'(sram_we_n), 1);
            chk("idle_oe", 32'(sram_dq_oe), 0);
        end

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 2);
            do_op("rand", k != 1, k != 0, BASE + 32'($urandom_range(0, 255)), $urandom);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end

        d = $urandom;
        rd_en = 1'b0; wr_en = 1'b1; address = 32'd1100; wdata = d;
        repeat (W + 1) begin @(posedge clk); #1; end
        chk("rstw_pre_we_n", 32'(sram_we_n), 0);
        rst = 1'b1; wr_en = 1'b0;
        #1;
        chk("rstw_we_n", 32'(sram_we_n), 1);
        chk("rstw_oe", 32'(sram_dq_oe), 0);
        chk("rstw_rdata", rdata, 0);
        chk("rstw_addr", 32'(sram_addr), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ref_mem[hw(32'd1100, 0)] = d[15:0];
        exp_rdata = '0;
        #1 chk("rstw_ready", 32'(ready), 1);
        do_op("rstw_load", 1, 0, 32'd1100, 32'h0);

        rd3 = 1'b1; addr3 = BASE; k = 0;
        #1 chk("w3_c0_ready", 32'(ready3), 0);
        while (!ready3 && k < 50) begin
            @(posedge clk); #1; k++;
            if (!ready3) chk("w3_addr", 32'(sa3), (k > 3) ? 1 : 0);
        end
        chk("w3_stall", k, 7);
        chk("w3_rdata", rdata3, 32'h9ABC5678);
        @(posedge clk); #1;
        rd3 = 1'b0;

        bad = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) bad++;
        if (mem[18'h3fffe] !== ref_mem[18'h3fffe] || mem[18'h3ffff] !== ref_mem[18'h3ffff]) bad++;
        chk("mem_sweep", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Memory-stage controller between the 32-bit pipeline and the board's external 16-bit asynchronous SRAM. It turns each load or store from the EXE/MEM register into two timed half-word SRAM accesses, low half first. It stalls the pipeline with `ready` until the access completes. On a load it presents the assembled 32-bit word on `rdata`, which feeds the `data_mem` input of the MEM/WB register.

## Interface
- `WAIT_CYC`, default 2: cycles per half-word access; must be ≥2.
- `MEM_BASE`, default 1024: byte address that maps to SRAM word 0.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `rd_en`, input, 1: load request from the EXE/MEM register.
- `wr_en`, input, 1: store request from the EXE/MEM register.
- `address`, input, 32: byte address (ALU result).
- `wdata`, input, 32: store data.
- `rdata`, output, 32: loaded word.
- `ready`, output, 1: low means freeze the pipeline.
- `sram_addr`, output, 18: SRAM half-word address.
- `sram_dq_o`, output, 16: write data driven to the SRAM.
- `sram_dq_i`, input, 16: read data from the SRAM.
- `sram_dq_oe`, output, 1: drive enable for the DQ pad.
- `sram_we_n`, output, 1: SRAM write strobe, active-low.

## Operation
- States: IDLE, LOW, HIGH, DONE.
- **Request acceptance:** in IDLE, `rd_en|wr_en` sampled at a clock edge latches `address`, `wdata` and the operation into internal registers, clears the wait counter, and moves to LOW.
- **Both enables high:** the controller performs a read; the write is ignored.
- **Word address:** word_addr[16:0] = (address − MEM_BASE)[18:2]. `sram_addr` = {word_addr, 1'b0} in LOW and {word_addr, 1'b1} in HIGH. Bits [1:0] of `address` are ignored. No range check is made; upper bits are truncated.
- **Phase length:** LOW and HIGH each last exactly WAIT_CYC cycles. LOW→HIGH and HIGH→DONE occur when the counter reaches WAIT_CYC−1. DONE lasts 1 cycle, then the state returns to IDLE unconditionally.
- **DONE does not re-trigger:** the same instruction still holds `rd_en` during DONE, but DONE never starts a new access.
- **Read:** `sram_dq_oe`=0. On the last cycle of LOW, `sram_dq_i` is captured into rdata[15:0]. On the last cycle of HIGH, it is captured into rdata[31:16]. `rdata` holds its value until the next read overwrites it; writes never change `rdata`.
- **Write:** `sram_dq_oe`=1 throughout LOW and HIGH. `sram_dq_o` = wdata_latched[15:0] in LOW and wdata_latched[31:16] in HIGH. `sram_we_n`=0 on every cycle of a phase except its last cycle, where it is 1; this gives the address/data hold cycle.
- **ready:** combinational, ready = ~(rd_en|wr_en) | (state==DONE). No request in IDLE gives ready=1.
- **Outputs outside LOW/HIGH:** `sram_we_n`=1, `sram_dq_oe`=0, and `sram_addr` holds its last value.

## Timing
- **Reset values:** state=IDLE, counter=0, `rdata`=0, `sram_addr`=0, `sram_dq_o`=0, `sram_dq_oe`=0, `sram_we_n`=1. `ready` follows its equation, so it is 1 when no request is present.
- **Stall length:** a request first visible in cycle 0 holds `ready` low for cycles 0..2·WAIT_CYC. `ready` is high in cycle 2·WAIT_CYC+1 (DONE). With WAIT_CYC=2 that is 5 stalled cycles and ready in cycle 5.
- **rdata timing:** `rdata` is valid from the DONE cycle onward, so the MEM/WB register captures it on the edge that ends DONE.
- **Back-to-back accesses:** a new request presented in the cycle after DONE is accepted from IDLE at that cycle's edge. The minimum spacing is 2·WAIT_CYC+2 cycles.
- **Reset mid-access:** the block returns immediately to IDLE with all reset values. A half-written word is left as-is in the SRAM.
- **Request dropped mid-access** (e.g. pipeline flush): the access completes regardless of `rd_en`/`wr_en`.

## Structure
- Shared package `sram_pkg`:
  - state enum (IDLE, LOW, HIGH, DONE);
  - MEM_BASE default;
  - SRAM_AW=18, SRAM_DW=16.
- Single module; the counter and the FSM are inline. No RTL sub-module.
- The bench provides a behavioral `sram_model`: 2^18×16 array that samples on the rising edge of `sram_we_n` and returns read data combinationally.

## Test plan
- **Load, default parameters:** SRAM[0]=0x1234, SRAM[1]=0xABCD; `rd_en`=1, `address`=1024 → `ready` low for cycles 0–4, high in cycle 5; `rdata`=0xABCD1234; `sram_addr` is 0 then 1; `sram_we_n` stays 1.
- **Store:** `wr_en`=1, `address`=1032, `wdata`=0xDEADBEEF → SRAM[4]=0xBEEF, SRAM[5]=0xDEAD; exactly two `sram_we_n` low pulses of 1 cycle each; `rdata` unchanged.
- **Store then load:** store to 1036, then load from 1036 one cycle after DONE → read returns the stored word; the second request is accepted with no lost cycle.
- **Both enables and idle behaviour:** `rd_en`=`wr_en`=1 at 1024 → a read is performed and the SRAM is unmodified. No request for 10 cycles → `ready`=1, `sram_we_n`=1, `sram_dq_oe`=0.
- **Reset mid-write:** `rst` asserted in the HIGH phase of a write → same cycle: `sram_we_n`=1, `sram_dq_oe`=0, `rdata`=0; state is IDLE after release; SRAM low half written, high half untouched.
- **WAIT_CYC=3:** load at 1024 → `ready` high in cycle 7; each phase holds `sram_addr` for 3 cycles.
